// File: rtl/rotate_rr_scheduler_pkg.sv
// Shared constants, FSM encoding and sizing helper for the rotate scheduler.
package rotate_rr_scheduler_pkg;

  localparam int unsigned ADDRESS_BITS_DEF = 3;
  localparam int unsigned ID_BITS_DEF      = 2;
  localparam int unsigned WIDTH            = 2 ** ADDRESS_BITS_DEF;
  localparam int unsigned NUM_REQ          = 2 ** ID_BITS_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  // Ceiling log2, for integrators sizing ID_BITS from a requester count.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((r < 32) && ((64'd1 << r) < 64'(n))) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/Barrel_Shift_R_Gen.sv
// Combinational rotate-right of num by amt positions, built as log2 stages.
module Barrel_Shift_R_Gen #(
  parameter int unsigned ADDRESS_BITS = 3
) (
  input  logic [(2**ADDRESS_BITS)-1:0] num,
  input  logic [ADDRESS_BITS-1:0]      amt,
  output logic [(2**ADDRESS_BITS)-1:0] result
);

  localparam int unsigned WIDTH = 2 ** ADDRESS_BITS;

  logic [WIDTH-1:0] stage;

  // Each stage rotates by 2**s when amount bit s is set.
  always_comb begin
    stage = num;
    for (int unsigned s = 0; s < ADDRESS_BITS; s++) begin
      if (amt[s]) begin
        stage = (stage >> (1 << s)) | (stage << (WIDTH - (1 << s)));
      end
    end
    result = stage;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin priority select with a pointer register advanced past each grant.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_BITS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [ID_BITS-1:0] gnt_idx_c,
  output logic               gnt_any_c
);

  logic [ID_BITS-1:0] ptr_q;
  logic [ID_BITS-1:0] ptr_d;
  logic               found;
  logic [ID_BITS-1:0] cand;

  // Scan from the pointer upward with wrap; first asserted request wins.
  always_comb begin
    found     = 1'b0;
    gnt_idx_c = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ptr_q + ID_BITS'(i);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt_idx_c = cand;
      end
    end
    gnt_any_c = en && found;
    gnt_c     = '0;
    if (gnt_any_c) begin
      gnt_c[gnt_idx_c] = 1'b1;
    end
    ptr_d = gnt_any_c ? (gnt_idx_c + ID_BITS'(1)) : ptr_q;
  end

  // Pointer register; index arithmetic wraps since NUM_REQ is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rotate_rr_scheduler.sv
// Shares one rotate-right datapath among requesters via round-robin arbitration,
// registering each result with its requester id into a one-entry output stage.
module rotate_rr_scheduler
  import rotate_rr_scheduler_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS = ADDRESS_BITS_DEF,
  parameter int unsigned ID_BITS      = ID_BITS_DEF
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [(2**ID_BITS)-1:0]                    req_valid,
  output logic [(2**ID_BITS)-1:0]                    req_ready,
  input  logic [(2**ID_BITS)*(2**ADDRESS_BITS)-1:0]  req_num,
  input  logic [(2**ID_BITS)*ADDRESS_BITS-1:0]       req_amt,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [(2**ADDRESS_BITS)-1:0]               out_data,
  output logic [ID_BITS-1:0]                         out_id,
  output logic                                       busy
);

  localparam int unsigned DW = 2 ** ADDRESS_BITS;
  localparam int unsigned NR = 2 ** ID_BITS;

  state_e               state_q;
  state_e               state_d;
  logic [DW-1:0]        out_data_q;
  logic [DW-1:0]        out_data_d;
  logic [ID_BITS-1:0]   out_id_q;
  logic [ID_BITS-1:0]   out_id_d;

  logic                    grant_en;
  logic                    accept;
  logic [ID_BITS-1:0]      win_idx;
  logic [DW-1:0]           sel_num;
  logic [ADDRESS_BITS-1:0] sel_amt;
  logic [DW-1:0]           rot_result;

  // Grant only when the output stage has room and reset is released.
  assign grant_en = rst_n && ((state_q == IDLE) || out_ready);

  rr_arbiter #(
    .NUM_REQ (NR),
    .ID_BITS (ID_BITS)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .en        (grant_en),
    .gnt_c     (req_ready),
    .gnt_idx_c (win_idx),
    .gnt_any_c (accept)
  );

  // Route the winner's operand and amount to the shared rotator.
  always_comb begin
    sel_num = '0;
    sel_amt = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (ID_BITS'(i) == win_idx) begin
        sel_num = req_num[i*DW +: DW];
        sel_amt = req_amt[i*ADDRESS_BITS +: ADDRESS_BITS];
      end
    end
  end

  Barrel_Shift_R_Gen #(
    .ADDRESS_BITS (ADDRESS_BITS)
  ) u_rot (
    .num    (sel_num),
    .amt    (sel_amt),
    .result (rot_result)
  );

  // Output-stage FSM: capture on accept, drop to IDLE on drain without refill.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = FULL;
          out_data_d = rot_result;
          out_id_d   = win_idx;
        end
      end
      FULL: begin
        if (accept) begin
          out_data_d = rot_result;
          out_id_d   = win_idx;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      out_data_q <= '0;
      out_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = out_valid || (|req_valid);

endmodule

// File: tb/tb_rotate_rr_scheduler.sv
// Self-checking bench for rotate_rr_scheduler: vector table, directed corner
// sequences and constrained-random traffic against a behavioural model.
module tb_rotate_rr_scheduler;

  localparam int AB = 3;
  localparam int IB = 2;
  localparam int W  = 8;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_num;
  logic [N*AB-1:0] req_amt;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [IB-1:0]   out_id;
  logic            busy;

  rotate_rr_scheduler #(.ADDRESS_BITS(AB), .ID_BITS(IB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_num   (req_num),
    .req_amt   (req_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Behavioural model state.
  int          m_ptr   = 0;
  bit          m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  int          m_id    = 0;

  typedef struct {
    int           r;
    logic [W-1:0] num;
    logic [AB-1:0] amt;
    logic [N-1:0] exp_ready;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Rotate right: take the window starting at bit amt of the doubled word.
  function automatic logic [W-1:0] rot(input logic [W-1:0] num, input int amt);
    logic [2*W-1:0] x;
    x = {num, num};
    return W'(x >> amt);
  endfunction

  // Winner is the valid index at the smallest cyclic distance from the pointer.
  function automatic int winner(input logic [N-1:0] v, input int p);
    int best, bestd, d;
    best = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        d = (i - p + N) % N;
        if (d < bestd) begin
          bestd = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int w;
    if (!rst_n || !(!m_valid || out_ready)) return '0;
    w = winner(req_valid, m_ptr);
    if (w < 0) return '0;
    return N'(1) << w;
  endfunction

  // One clock: check combinational outputs, advance model at the edge, check registers.
  task automatic cycle();
    logic [N-1:0] er;
    int w;
    #3;
    er = exp_ready();
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("busy", 32'(busy), 32'(m_valid || (|req_valid)));
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_id    = 0;
      m_ptr   = 0;
    end else if (er != '0) begin
      w = winner(req_valid, m_ptr);
      m_valid = 1'b1;
      m_data  = rot(req_num[w*W +: W], int'(req_amt[w*AB +: AB]));
      m_id    = w;
      m_ptr   = (w + 1) % N;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_id", 32'(out_id), 32'(m_id));
  endtask

  logic [W-1:0]  held_data;
  logic [IB-1:0] held_id;
  logic [N-1:0]  acc;

  initial begin
    vecs[0] = '{r: 2, num: 8'hB4, amt: 3'd3, exp_ready: 4'b0100, exp_data: 8'h96};
    vecs[1] = '{r: 0, num: 8'h01, amt: 3'd1, exp_ready: 4'b0001, exp_data: 8'h80};
    vecs[2] = '{r: 1, num: 8'h5A, amt: 3'd0, exp_ready: 4'b0010, exp_data: 8'h5A};
    vecs[3] = '{r: 3, num: 8'h80, amt: 3'd7, exp_ready: 4'b1000, exp_data: 8'h01};
    vecs[4] = '{r: 1, num: 8'hF0, amt: 3'd4, exp_ready: 4'b0010, exp_data: 8'h0F};

    // Reset with all requesters valid.
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_num   = 32'h44332211;
    req_amt   = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    rst_n = 1'b1;
    #2;
    chk("first_grant", 32'(req_ready), 32'b0001);
    cycle();
    req_valid = '0;

    // Single-request vector table.
    foreach (vecs[k]) begin
      req_valid = '0;
      req_valid[vecs[k].r] = 1'b1;
      req_num[vecs[k].r*W +: W]   = vecs[k].num;
      req_amt[vecs[k].r*AB +: AB] = vecs[k].amt;
      out_ready = 1'b1;
      #2;
      chk("tbl_ready", 32'(req_ready), 32'(vecs[k].exp_ready));
      cycle();
      chk("tbl_data", 32'(out_data), 32'(vecs[k].exp_data));
      chk("tbl_id", 32'(out_id), 32'(vecs[k].r));
      req_valid = '0;
    end
    cycle();

    // Fairness and wrap after a fresh reset.
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    req_num   = 32'hA1B2C3D4;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("fair_id", 32'(out_id), 32'(k % 4));
      chk("fair_valid", 32'(out_valid), 32'h1);
    end

    // Backpressure holds the result; release picks the next requester at once.
    out_ready = 1'b0;
    held_data = out_data;
    held_id   = out_id;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_data", 32'(out_data), 32'(held_data));
      chk("bp_id", 32'(out_id), 32'(held_id));
      chk("bp_ready", 32'(req_ready), 32'h0);
    end
    out_ready = 1'b1;
    #2;
    chk("bp_release_ready", 32'(req_ready), 32'b0001);
    cycle();
    chk("bp_release_id", 32'(out_id), 32'h0);
    chk("bp_release_valid", 32'(out_valid), 32'h1);

    // Reset while holding a result.
    req_valid = 4'b0100;
    req_num[2*W +: W]   = 8'hB4;
    req_amt[2*AB +: AB] = 3'd3;
    cycle();
    chk("mid_data", 32'(out_data), 32'h96);
    req_valid = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    cycle();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    req_valid = 4'b1001;
    #2;
    chk("mid_rst_winner", 32'(req_ready), 32'b0001);
    cycle();
    chk("mid_rst_id", 32'(out_id), 32'h0);
    req_valid = '0;
    cycle();

    // Random traffic; pending requests hold their payload until accepted.
    for (int k = 0; k < 400; k++) begin
      acc = exp_ready();
      cycle();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || acc[i] || !rst_n) begin
          req_valid[i]        = ($urandom_range(0, 2) != 0);
          req_num[i*W +: W]   = W'($urandom);
          req_amt[i*AB +: AB] = AB'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 60) != 0);
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/rotate_rr_scheduler.md
Name: rotate_rr_scheduler

Overview:
Shares a single combinational rotate-right datapath (Barrel_Shift_R_Gen) between NUM_REQ requesters. A round-robin arbiter grants one requester per accepted transaction. The rotated result is registered into a one-entry output stage, tagged with the requester id, and drained over a valid/ready handshake. Sits between multiple issuing units and the single shared rotator instance.

Parameters:
ADDRESS_BITS, 3, rotate-amount width; data WIDTH = 2**ADDRESS_BITS (localparam).
ID_BITS, 2, requester-id width; NUM_REQ = 2**ID_BITS (localparam).

Ports:
clk  in  1  single clock; all logic on rising edge.
rst_n  in  1  synchronous, active-low reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
req_num  in  NUM_REQ*WIDTH  operands; requester i at bits [i*WIDTH +: WIDTH].
req_amt  in  NUM_REQ*ADDRESS_BITS  rotate amounts; requester i at [i*ADDRESS_BITS +: ADDRESS_BITS].
out_valid  out  1  result register holds a valid result.
out_ready  in  1  downstream accepts the result.
out_data  out  WIDTH  rotated result.
out_id  out  ID_BITS  index of the requester that produced out_data.
busy  out  1  out_valid OR any req_valid (status only).

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous, active-low, rst_n.
- Reset values: out_valid=0, out_data=0, out_id=0, round-robin pointer=0, FSM=IDLE. req_ready is combinational and therefore 0 while rst_n=0.
- Reset mid-operation: a held result is discarded. No handshake completes in the reset cycle.
- Arbitration:
  - Round robin over req_valid, starting at pointer P.
  - Winner = first asserted index in P, P+1, …, NUM_REQ-1, 0, …, P-1 (mod NUM_REQ).
  - After an accepted request from requester g, P <= g+1 mod NUM_REQ (wraps from NUM_REQ-1 to 0).
  - P is unchanged when nothing is accepted.
- Space in the output stage: space = !out_valid || out_ready.
- Grant: req_ready[winner] = 1 only when space=1 and rst_n=1. All other bits are 0. With no valid requests, req_ready=0.
- Requesters must hold req_valid, req_num and req_amt stable until accepted. req_ready never depends on the requester's own ready.
- Datapath: combinational rotate-right of the winner's operand.
  - out_data(next) = {num[amt-1:0], num[WIDTH-1:amt]}; amt=0 passes num unchanged.
  - Latency: 1 cycle from the accept edge to out_valid.
- FSM:
  - IDLE (out_valid=0):
    - on accept -> FULL, capturing the result and out_id=winner.
  - FULL (out_valid=1):
    - out_ready=1 with an accept in the same cycle -> stay FULL with the new result (back-to-back, one result per cycle);
    - out_ready=1 with no request -> IDLE, out_valid=0;
    - out_ready=0 -> hold out_data and out_id stable, req_ready all 0.
- Simultaneous drain and accept in one cycle is legal and loses no data.
- Throughput: sustained 1 result/cycle with out_ready tied high.
- Fairness: with all requesters continuously valid and out_ready=1, grants cycle 0,1,2,3,0,… No requester waits more than NUM_REQ accepts.
- out_valid never deasserts without a handshake, except on reset.

Decomposition:
- Shared package/header holds:
  - localparams WIDTH and NUM_REQ;
  - FSM state encoding: IDLE=1'b0, FULL=1'b1;
  - a constant function clog2 for integrators sizing ID_BITS.
- Sub-modules:
  - the existing Barrel_Shift_R_Gen (ADDRESS_BITS passed through) for the datapath; no new rotator;
  - one natural new sub-module, rr_arbiter (NUM_REQ-wide round-robin priority select with pointer register, grant-enable input, one-hot grant and encoded index outputs).

Test Plan:
1. Reset: rst_n=0 for 2 cycles with req_valid=4'b1111 -> req_ready=0, out_valid=0, out_data=0. Release reset -> first grant to requester 0.
2. Single request: requester 2, num=8'hB4, amt=3, out_ready=1 -> req_ready=4'b0100 in that cycle. Next cycle out_valid=1, out_data=8'h96, out_id=2.
3. Edge amounts:
   - num=8'h01, amt=1 -> out_data=8'h80.
   - num=8'h5A, amt=0 -> out_data=8'h5A.
   - num=8'h80, amt=7 -> out_data=8'h01.
4. Fairness/wrap: all four valid, out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3 on consecutive cycles, out_valid held 1.
5. Backpressure: result held with out_ready=0 for 5 cycles while requests pend -> out_data and out_id stable, req_ready=0. Raise out_ready -> the next winner (pointer order) is accepted in the same cycle and appears on the next cycle with no bubble.
6. Reset mid-operation: out_valid=1 holding 8'h96, drop rst_n for 1 cycle -> out_valid=0 and the pointer resets. The held result is never handshaked; after release, requester 0 wins over 3.
